// File: rtl/muldiv_unit.sv
// Iterative 16x16 unsigned multiply / divide unit with register-file write-back.
// One iteration per RUN cycle; the result is written back in a single WB cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [3:0]  dest_reg,
    output logic        busy,
    output logic        done,
    output logic        reg_write,
    output logic [3:0]  write_reg,
    output logic [15:0] write_data,
    output logic        div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // RUN   | steps 0..15 iterate mul and div, step 16 latches the result
    // WB    | one-cycle register-file write, done pulse
    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    localparam logic [1:0] OP_MULLO = 2'b00;
    localparam logic [1:0] OP_MULHI = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    state_t      state;
    logic [4:0]  step;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  dest_q;
    logic [31:0] prod;
    logic [16:0] rem;
    logic [15:0] quo;

    logic [16:0] mul_sum;
    logic [17:0] rem_shift;
    logic        rem_ge;
    logic [16:0] rem_next;
    logic [15:0] result;
    logic        dbz;

    // Shift-add multiply keeps the multiplier in prod[15:0]; restoring divide
    // shifts the dividend out of quo while quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, prod[31:16]} + (prod[0] ? {1'b0, a_q} : 17'd0);
        rem_shift = {rem, quo[15]};
        rem_ge    = (rem_shift >= {2'b00, b_q});
        rem_next  = rem_ge ? 17'(rem_shift - {2'b00, b_q}) : 17'(rem_shift);
        dbz       = op_q[1] && (b_q == 16'h0000);
        case (op_q)
            OP_MULLO: result = prod[15:0];
            OP_MULHI: result = prod[31:16];
            OP_DIVU:  result = quo;
            default:  result = rem[15:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            step        <= 5'd0;
            op_q        <= 2'b00;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            dest_q      <= 4'h0;
            prod        <= 32'h0000_0000;
            rem         <= 17'h0_0000;
            quo         <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            reg_write   <= 1'b0;
            write_reg   <= 4'h0;
            write_data  <= 16'h0000;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            reg_write   <= 1'b0;
            write_reg   <= 4'h0;
            write_data  <= 16'h0000;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        dest_q <= dest_reg;
                        step   <= 5'd0;
                        prod   <= {16'h0000, operand_b};
                        rem    <= 17'h0_0000;
                        quo    <= operand_a;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (step == 5'd16) begin
                        reg_write   <= 1'b1;
                        done        <= 1'b1;
                        write_reg   <= dest_q;
                        write_data  <= result;
                        div_by_zero <= dbz;
                        state       <= WB;
                    end else begin
                        step <= step + 5'd1;
                        prod <= {mul_sum, prod[15:1]};
                        rem  <= rem_next;
                        quo  <= {quo[14:0], rem_ge};
                    end
                end
                WB: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
